// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between NUM_REQ requesters.
// Latches a plaintext/key pair, runs the core once, returns the tagged result.
//
// state | meaning
// IDLE  | arbitrating; req_ready one-hot on the round-robin winner
// RUN   | core_en high, waiting for core_done or the timeout
// RESP  | result held on rsp_* until rsp_ready
module aes_core_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plaintext,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   core_en,
  output logic [127:0]           core_plaintext,
  output logic [127:0]           core_key,
  input  logic                   core_done,
  input  logic [127:0]           core_ciphertext,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              grant;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt_q;
  logic [127:0]      pt_q;
  logic [127:0]      key_q;
  logic [ID_W-1:0]   id_q;
  logic [127:0]      data_q;
  logic              err_q;

  // Search starts one past the last served channel so every waiter gets a turn.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign grant       = (state_q == IDLE) && found;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    req_ready = '0;
    if (grant && !rst) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = RUN;
      RUN:     if (core_done || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant) begin
            pt_q  <= req_plaintext[128*int'(winner) +: 128];
            key_q <= req_key[128*int'(winner) +: 128];
            id_q  <= winner;
            ptr_q <= winner;
            cnt_q <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // A done arriving on the last allowed cycle still counts as success.
          if (core_done) begin
            data_q <= core_ciphertext;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_en        = (state_q == RUN);
  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_data       = data_q;
  assign rsp_id         = id_q;
  assign rsp_err        = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter; the bench plays the AES core by
// pulsing core_done with known ciphertexts.
module tb_aes_core_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_plaintext;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   core_en;
  logic [127:0]           core_plaintext;
  logic [127:0]           core_key;
  logic                   core_done;
  logic [127:0]           core_ciphertext;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  logic [1:0]             rsp_id;
  logic                   rsp_err;
  logic                   busy;

  int n_cmp  = 0;
  int n_fail = 0;

  aes_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .core_en(core_en), .core_plaintext(core_plaintext), .core_key(core_key),
    .core_done(core_done), .core_ciphertext(core_ciphertext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, runs the job for lat cycles of core_en, accepts the response.
  task automatic serve(input int lat, input logic [127:0] ct,
                       output int id, output logic [127:0] data, output logic err);
    int w;
    w = 0;
    #1;
    while (req_ready == '0 && w < 20) begin
      tick();
      #1;
      w++;
    end
    n_cmp++;
    if (req_ready == '0) begin
      n_fail++;
      $display("FAIL serve_grant: req_ready stayed %b for 20 cycles, required a grant", req_ready);
      id = -1; data = '0; err = 1'b1;
      return;
    end
    tick();
    repeat (lat - 1) tick();
    core_done = 1'b1; core_ciphertext = ct;
    tick();
    core_done = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_rsp_valid: got %b required 1", rsp_valid);
    end
    id = int'(rsp_id); data = rsp_data; err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0; core_done = 1'b0;
    core_ciphertext = '0; req_plaintext = '0; req_key = '0;
    tick(); tick();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 0000", req_ready);
    end
    n_cmp++;
    if ({core_en, rsp_valid, rsp_err, busy, rsp_id} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b vld=%b err=%b busy=%b id=%0d required all 0",
               core_en, rsp_valid, rsp_err, busy, rsp_id);
    end
    n_cmp++;
    if ({core_plaintext, core_key, rsp_data} !== 384'b0) begin
      n_fail++; $display("FAIL reset_data: got pt=%h key=%h data=%h required 0",
                         core_plaintext, core_key, rsp_data);
    end
    req_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    logic [127:0] pt, key, ct;
    pt  = 128'h00112233445566778899aabbccddeeff;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    req_plaintext[2*128 +: 128] = pt;
    req_key[2*128 +: 128]       = key;
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if ({req_ready, core_en} !== {4'b0100, 1'b0}) begin
      n_fail++; $display("FAIL fips_grant: got ready=%b en=%b required 0100/0", req_ready, core_en);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if ({core_plaintext, core_key} !== {pt, key}) begin
      n_fail++; $display("FAIL fips_latch: got pt=%h key=%h required %h %h", core_plaintext, core_key, pt, key);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({core_en, rsp_valid, busy} !== 3'b101) begin
        n_fail++; $display("FAIL fips_run%0d: got en/vld/busy=%b required 101", k, {core_en, rsp_valid, busy});
      end
      tick();
    end
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_fail++; $display("FAIL fips_en_done_cycle: got %b required 1", core_en);
    end
    core_done = 1'b1; core_ciphertext = ct;
    tick();
    core_done = 1'b0; core_ciphertext = '0;
    n_cmp++;
    if ({core_en, rsp_valid, busy, rsp_err, rsp_id} !== 6'b011010) begin
      n_fail++; $display("FAIL fips_resp_ctrl: got en=%b vld=%b busy=%b err=%b id=%0d required 0 1 1 0 2",
                         core_en, rsp_valid, busy, rsp_err, rsp_id);
    end
    n_cmp++;
    if (rsp_data !== ct) begin
      n_fail++; $display("FAIL fips_rsp_data: got %h required %h", rsp_data, ct);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, core_en} !== 3'b000) begin
      n_fail++; $display("FAIL fips_after_rsp: got vld/busy/en=%b required 000", {rsp_valid, busy, core_en});
    end
  endtask

  task automatic test_fairness();
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int id;
    logic [127:0] data, ct;
    logic err;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < NUM_REQ; c++) begin
      req_plaintext[c*128 +: 128] = {32'h1111_0000 + 32'(c), 96'h0};
      req_key[c*128 +: 128]       = {96'h0, 32'h2222_0000 + 32'(c)};
    end
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      ct = {32'hc0de_0000 + 32'(j), 96'h5a};
      serve(3, ct, id, data, err);
      n_cmp++;
      if (id !== exp_order[j] || data !== ct || err !== 1'b0) begin
        n_fail++; $display("FAIL fair_job%0d: got id=%0d data=%h err=%b required id=%0d data=%h err=0",
                           j, id, data, err, exp_order[j], ct);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_wrap_skip();
    int id;
    logic [127:0] data;
    logic err;
    req_valid = 4'b1010;
    serve(2, 128'h1, id, data, err);
    n_cmp++;
    if (id !== 1 || data !== 128'h1) begin
      n_fail++; $display("FAIL wrap_first: got id=%0d data=%h required id=1 data=1", id, data);
    end
    serve(2, 128'h3, id, data, err);
    n_cmp++;
    if (id !== 3 || data !== 128'h3) begin
      n_fail++; $display("FAIL wrap_second: got id=%0d data=%h required id=3 data=3", id, data);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int id;
    logic [127:0] data;
    logic err;
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL to_grant: got %b required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < TIMEOUT; k++) begin
      n_cmp++;
      if ({core_en, rsp_valid, busy} !== 3'b101) begin
        n_fail++; $display("FAIL to_run_cycle%0d: got en/vld/busy=%b required 101", k + 1, {core_en, rsp_valid, busy});
      end
      tick();
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, core_en, rsp_id} !== 5'b11000 || rsp_data !== 128'h0) begin
      n_fail++; $display("FAIL to_abort: got vld=%b err=%b en=%b id=%0d data=%h required 1 1 0 0 0",
                         rsp_valid, rsp_err, core_en, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    serve(4, 128'hfeed, id, data, err);
    n_cmp++;
    if (id !== 1 || data !== 128'hfeed || err !== 1'b0) begin
      n_fail++; $display("FAIL to_next_job: got id=%0d data=%h err=%b required 1 feed 0", id, data, err);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [127:0] ct;
    ct = 128'hbeef_cafe;
    req_valid = 4'b0100;
    #1;
    tick();
    tick();
    core_done = 1'b1; core_ciphertext = ct;
    tick();
    core_done = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        core_done = 1'b1; core_ciphertext = 128'hdead;
      end else begin
        core_done = 1'b0;
      end
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, core_en} !== {1'b1, 2'd2, 1'b0, ct, 4'b0000, 1'b0}) begin
        n_fail++; $display("FAIL bp_cycle%0d: got vld=%b id=%0d err=%b data=%h ready=%b en=%b required 1 2 0 %h 0000 0",
                           k, rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, core_en, ct);
      end
      tick();
    end
    core_done = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int id;
    logic [127:0] data;
    logic err;
    req_valid = 4'b1000;
    #1;
    tick();
    tick();
    n_cmp++;
    if (core_en !== 1'b1) begin
      n_fail++; $display("FAIL rst_run_pre: got core_en=%b required 1", core_en);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = '0;
    n_cmp++;
    if ({core_en, rsp_valid, busy} !== 3'b000 || core_plaintext !== 128'h0) begin
      n_fail++; $display("FAIL rst_run_post: got en/vld/busy=%b pt=%h required 000 0",
                         {core_en, rsp_valid, busy}, core_plaintext);
    end
    for (int k = 0; k < 5; k++) begin
      core_done = (k == 2);
      core_ciphertext = 128'h77;
      tick();
      n_cmp++;
      if ({rsp_valid, busy} !== 2'b00) begin
        n_fail++; $display("FAIL rst_no_rsp%0d: got vld/busy=%b required 00", k, {rsp_valid, busy});
      end
    end
    core_done = 1'b0;
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rst_next_grant: got %b required 0001", req_ready);
    end
    serve(2, 128'h0a0b, id, data, err);
    n_cmp++;
    if (id !== 0 || data !== 128'h0a0b || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_next_job: got id=%0d data=%h err=%b required 0 0a0b 0", id, data, err);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_fairness();
    test_wrap_skip();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
